// File: rtl/seq_detect_pkg.sv
// Shared types and the round-robin pick helper
// for the serial pattern-detector scheduler.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int RR_MAX = 32;

  // First valid index at or after ptr, wrapping modulo n (n <= RR_MAX).
  function automatic int rr_pick(
    input logic [RR_MAX-1:0] valid,
    input int                ptr,
    input int                n
  );
    int idx;
    int g;
    g = ptr;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && valid[idx[4:0]]) g = idx;
    end
    return g;
  endfunction

endpackage

// File: rtl/seq_detect_sched_det.sv
// Moore serial pattern detector: history, saturating
// seen-count and a registered hit flag.
module moore_pattern_det #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int SW = $clog2(PAT_W + 1);
  localparam logic [SW-1:0] SEEN_FULL = SW'(PAT_W);
  localparam logic [SW-1:0] SEEN_ARM  = SW'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q;
  logic [PAT_W-1:0] hist_d;
  logic [SW-1:0]    seen_q;

  assign hist_d = {hist_q, bit_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      seen_q <= '0;
      hit    <= 1'b0;
    end else if (clr) begin
      hist_q <= '0;
      seen_q <= '0;
      hit    <= 1'b0;
    end else if (en) begin
      hist_q <= hist_d[PAT_W-2:0];
      if (seen_q != SEEN_FULL) seen_q <= seen_q + 1'b1;
      hit <= (hist_d == pattern) && (seen_q >= SEEN_ARM);
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler feeding request words MSB-first
// into one shared Moore detector; returns hit counts.
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int WORD_W = 8,
  parameter int PAT_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WORD_W-1:0]    req_word,
  input  logic [PAT_W-1:0]           cfg_pattern,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [$clog2(WORD_W+1)-1:0] resp_count,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int BW = $clog2(WORD_W);
  localparam logic [CW-1:0] CMAX = CW'(WORD_W - PAT_W + 1);

  state_t state_q, state_d;

  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     gnt;
  logic [IW-1:0]     ptr_nxt;
  logic [WORD_W-1:0] sel_word;
  logic [WORD_W-1:0] word_q;
  logic [PAT_W-1:0]  pat_q;
  logic [BW-1:0]     bit_idx_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     id_q;
  logic              accept;
  logic              hit;
  logic              counting;

  assign gnt = IW'(rr_pick(RR_MAX'(req_valid), int'(ptr_q), N_REQ));
  assign ptr_nxt = (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
  assign accept = (state_q == IDLE) && (|req_valid);
  assign counting = (state_q == SHIFT) || (state_q == FLUSH);

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt == IW'(i)) sel_word = req_word[i*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|req_valid) state_d = SHIFT;
      SHIFT: if (bit_idx_q == '0) state_d = FLUSH;
      FLUSH: state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rst so every output reads 0 while in reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = rst && accept && (gnt == IW'(i));
    resp_valid = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      word_q    <= '0;
      pat_q     <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
    end else begin
      if (accept) begin
        word_q    <= sel_word;
        pat_q     <= cfg_pattern;
        bit_idx_q <= BW'(WORD_W - 1);
        cnt_q     <= '0;
        id_q      <= gnt;
        ptr_q     <= ptr_nxt;
      end else if (state_q == SHIFT) begin
        word_q <= word_q << 1;
        if (bit_idx_q != '0) bit_idx_q <= bit_idx_q - 1'b1;
      end
      if (counting && hit && cnt_q != CMAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  moore_pattern_det #(
    .PAT_W(PAT_W)
  ) u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state_q == SHIFT),
    .bit_in (word_q[WORD_W-1]),
    .pattern(pat_q),
    .hit    (hit)
  );

  assign resp_id    = id_q;
  assign resp_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: randomized
// requesters against a window-counting reference model.
module tb_seq_detect_sched;

  localparam int N = 2;
  localparam int W = 8;
  localparam int P = 3;

  typedef struct {
    int id;
    int cnt;
    int cyc;
  } exp_t;

  logic                     clk;
  logic                     rst;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N*W-1:0]           req_word;
  logic [P-1:0]             cfg_pattern;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [$clog2(N)-1:0]     resp_id;
  logic [$clog2(W+1)-1:0]   resp_count;
  logic                     busy;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  int ptr_m = 0;
  int mode = 0;
  bit rnd_cfg = 0;
  bit wd_en = 0;

  exp_t sb[$];
  logic [W-1:0] src_q[N][$];

  seq_detect_sched #(.N_REQ(N), .WORD_W(W), .PAT_W(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_word   (req_word),
    .cfg_pattern(cfg_pattern),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_count (resp_count),
    .busy       (busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Count every PAT_W-wide window of the word equal to the pattern.
  function automatic int hits(input logic [W-1:0] w, input logic [P-1:0] p);
    int n = 0;
    for (int s = 0; s <= W - P; s++)
      if (w[W-1-s -: P] == p) n++;
    return n;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (src_q[i].size() > 0);
      req_word[i*W +: W] = req_valid[i] ? src_q[i][0] : '0;
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    logic [N-1:0] exp_rdy;
    int g;
    @(negedge clk);
    acc = req_valid & req_ready;
    exp_rdy = '0;
    if (sb.size() == 0 && req_valid != '0) begin
      g = pick(req_valid, ptr_m);
      exp_rdy[g] = 1'b1;
      sb.push_back('{id: g, cnt: hits(src_q[g][0], cfg_pattern), cyc: cyc});
      ptr_m = (g + 1) % N;
    end
    chk("req_ready", int'(req_ready), int'(exp_rdy));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) src_q[i].delete(0);
      else if (wd_en && req_valid[i] && src_q[i].size() > 0 &&
               $urandom_range(0, 7) == 0) src_q[i].delete(0);
    end
    drive();
    resp_ready = (mode == 0) ? 1'b1 :
                 (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    if (rnd_cfg && $urandom_range(0, 9) == 0) cfg_pattern = P'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    int pend;
    pend = sb.size();
    for (int i = 0; i < N; i++) pend += src_q[i].size();
    while (pend != 0 && k < 400) begin
      step();
      k++;
      pend = sb.size();
      for (int i = 0; i < N; i++) pend += src_q[i].size();
    end
    vec++;
    if (pend != 0) begin
      miss++;
      $display("FAIL drain_timeout: %0d items pending, expected 0", pend);
    end
  endtask

  task automatic wait_accept();
    int k = 0;
    while (sb.size() == 0 && k < 50) begin
      step();
      k++;
    end
    vec++;
    if (sb.size() == 0) begin
      miss++;
      $display("FAIL accept_timeout: no grant after %0d cycles, expected one", k);
    end
  endtask

  // Response monitor: compares against the scoreboard head, pops after the edge.
  initial begin
    bit prev_v;
    bit hs;
    prev_v = 0;
    forever begin
      @(negedge clk);
      hs = 0;
      if (resp_valid) begin
        chk("ready_in_resp", int'(req_ready), 0);
        if (sb.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL unexpected_resp: id %0d count %0d, expected no response",
                   resp_id, resp_count);
        end else begin
          if (!prev_v) chk("latency", cyc - sb[0].cyc, W + 2);
          chk("resp_id", int'(resp_id), sb[0].id);
          chk("resp_count", int'(resp_count), sb[0].cnt);
          hs = resp_ready;
        end
      end
      prev_v = resp_valid && !resp_ready;
      @(posedge clk);
      if (hs && sb.size() > 0) sb.delete(0);
    end
  end

  initial begin
    rst = 0;
    req_valid = '1;
    req_word = '0;
    cfg_pattern = 3'b101;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_id", int'(resp_id), 0);
    chk("rst_resp_count", int'(resp_count), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1;

    src_q[0].push_back(8'hAA);
    src_q[0].push_back(8'hAA);
    src_q[1].push_back(8'h00);
    src_q[1].push_back(8'h00);
    drain();

    foreach (src_q[0][i]) src_q[0].delete(i);
    src_q[0].push_back(8'hAA);
    src_q[0].push_back(8'h55);
    src_q[0].push_back(8'hFF);
    src_q[0].push_back(8'h00);
    src_q[0].push_back(8'hB5);
    src_q[0].push_back(8'h02);
    src_q[0].push_back(8'hA0);
    drain();

    mode = 2;
    src_q[1].push_back(8'hAA);
    for (int k = 0; k < 60 && !resp_valid; k++) step();
    repeat (20) step();
    chk("held_busy", int'(busy), 1);
    mode = 0;
    drain();

    src_q[0].push_back(8'hAA);
    wait_accept();
    repeat (2) step();
    cfg_pattern = 3'b111;
    drain();
    cfg_pattern = 3'b101;

    src_q[0].push_back(8'hAA);
    wait_accept();
    repeat (3) step();
    rst = 0;
    #1;
    chk("mid_rst_resp_valid", int'(resp_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_req_ready", int'(req_ready), 0);
    chk("mid_rst_resp_count", int'(resp_count), 0);
    sb.delete();
    ptr_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    src_q[0].push_back(8'h55);
    src_q[1].push_back(8'hFF);
    drain();

    mode = 1;
    rnd_cfg = 1;
    wd_en = 1;
    repeat (600) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 2 && $urandom_range(0, 2) == 0)
          src_q[i].push_back(W'($urandom));
      step();
    end
    wd_en = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
